// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the tile instruction sequencer: FSM states,
// instruction field positions, the quiescent instruction word and the
// default flush depth.
package inst_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WFETCH = 3'd1,
    S_WLOAD  = 3'd2,
    S_FLUSH  = 3'd3,
    S_XFETCH = 3'd4,
    S_EXEC   = 3'd5,
    S_DRAIN  = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  localparam int ROW_DEF    = 8;
  localparam int COL_DEF    = 8;
  localparam int ADDR_W_DEF = 11;
  localparam int INST_W     = 38;

  // Instruction field positions
  localparam int BIT_RELU     = 37;
  localparam int BIT_SFU_ACC  = 36;
  localparam int BIT_LD_MODE  = 35;
  localparam int BIT_OP_MODE  = 34;
  localparam int BIT_ACC      = 33;
  localparam int BIT_CEN_PMEM = 32;
  localparam int BIT_WEN_PMEM = 31;
  localparam int LSB_A_PMEM   = 20;
  localparam int BIT_CEN_XMEM = 19;
  localparam int BIT_WEN_XMEM = 18;
  localparam int LSB_A_XMEM   = 7;
  localparam int BIT_OFIFO_RD = 6;
  localparam int BIT_IFIFO_WR = 5;
  localparam int BIT_IFIFO_RD = 4;
  localparam int BIT_L0_RD    = 3;
  localparam int BIT_L0_WR    = 2;
  localparam int BIT_EXECUTE  = 1;
  localparam int BIT_LOAD     = 0;

  // Both SRAMs deselected and write-disabled, every control strobe low
  localparam logic [INST_W-1:0] IDLE_WORD = 38'h01800C0000;

  // Pipeline drain depth after a kernel load: long enough for the last
  // weight to ripple through every row and column of the array.
  function automatic int flush_depth(input int rows, input int cols);
    return rows + cols;
  endfunction

endpackage

// File: rtl/inst_sequencer.sv
// Tile instruction sequencer: walks weight fetch, kernel load, flush,
// activation fetch, execute and OFIFO drain, emitting one registered
// instruction word per cycle to the core.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int ROW     = ROW_DEF,
  parameter int COL     = COL_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INST_BW = INST_W,
  parameter int FLUSH   = flush_depth(ROW, COL)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               relu,
  input  logic               sfu_acc,
  input  logic [ADDR_W-1:0]  w_base,
  input  logic [ADDR_W-1:0]  x_base,
  input  logic [ADDR_W-1:0]  p_base,
  input  logic [ADDR_W-1:0]  n_act,
  input  logic               ofifo_valid,
  output logic [INST_BW-1:0] inst,
  output logic               busy,
  output logic               done
);

  localparam logic [ADDR_W-1:0] ROW_C      = ADDR_W'(ROW);
  localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(ROW - 1);
  localparam logic [ADDR_W-1:0] FLUSH_LAST = ADDR_W'(FLUSH - 1);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   step_q, step_d;    // position within the current phase
  logic [ADDR_W-1:0]   drain_q, drain_d;  // pmem writes completed so far
  logic [ADDR_W-1:0]   w_base_q, w_base_d;
  logic [ADDR_W-1:0]   x_base_q, x_base_d;
  logic [ADDR_W-1:0]   p_base_q, p_base_d;
  logic [ADDR_W-1:0]   n_act_q, n_act_d;
  logic [INST_BW-1:0]  inst_q, inst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next state, counters and the instruction word for the next cycle
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    drain_d  = drain_q;
    w_base_d = w_base_q;
    x_base_d = x_base_q;
    p_base_d = p_base_q;
    n_act_d  = n_act_q;
    inst_d   = IDLE_WORD;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          w_base_d = w_base;
          x_base_d = x_base;
          p_base_d = p_base;
          n_act_d  = n_act;
          step_d   = '0;
          drain_d  = '0;
          if (n_act != '0) begin
            state_d = S_WFETCH;
            busy_d  = 1'b1;
          end else begin
            // Empty tile: report completion without touching either SRAM
            state_d = S_DONE;
          end
        end
      end

      S_WFETCH: begin
        // Read k is issued at step k; its L0 write lands one step later,
        // so this phase runs ROW+1 cycles.
        inst_d[BIT_LD_MODE] = 1'b1;
        if (step_q != ROW_C) begin
          inst_d[BIT_CEN_XMEM]              = 1'b0;
          inst_d[BIT_WEN_XMEM]              = 1'b1;
          inst_d[LSB_A_XMEM +: ADDR_W]      = w_base_q + step_q;
        end
        if (step_q != '0) inst_d[BIT_L0_WR] = 1'b1;
        if (step_q == ROW_C) begin
          state_d = S_WLOAD;
          step_d  = '0;
        end else begin
          step_d = step_q + ONE;
        end
      end

      S_WLOAD: begin
        inst_d[BIT_L0_RD] = 1'b1;
        inst_d[BIT_LOAD]  = 1'b1;
        if (step_q == ROW_LAST) begin
          state_d = S_FLUSH;
          step_d  = '0;
        end else begin
          step_d = step_q + ONE;
        end
      end

      S_FLUSH: begin
        if (step_q == FLUSH_LAST) begin
          state_d = S_XFETCH;
          step_d  = '0;
        end else begin
          step_d = step_q + ONE;
        end
      end

      S_XFETCH: begin
        // Same read/write skew as the weight fetch, n_act+1 cycles
        if (step_q != n_act_q) begin
          inst_d[BIT_CEN_XMEM]              = 1'b0;
          inst_d[BIT_WEN_XMEM]              = 1'b1;
          inst_d[LSB_A_XMEM +: ADDR_W]      = x_base_q + step_q;
        end
        if (step_q != '0) inst_d[BIT_L0_WR] = 1'b1;
        if (step_q == n_act_q) begin
          state_d = S_EXEC;
          step_d  = '0;
        end else begin
          step_d = step_q + ONE;
        end
      end

      S_EXEC: begin
        inst_d[BIT_L0_RD]   = 1'b1;
        inst_d[BIT_EXECUTE] = 1'b1;
        if (step_q == n_act_q - ONE) begin
          state_d = S_DRAIN;
          step_d  = '0;
        end else begin
          step_d = step_q + ONE;
        end
      end

      S_DRAIN: begin
        // Show-ahead OFIFO: the pop and the pmem write share one word
        if (ofifo_valid) begin
          inst_d[BIT_RELU]                 = relu;
          inst_d[BIT_SFU_ACC]              = sfu_acc;
          inst_d[BIT_OFIFO_RD]             = 1'b1;
          inst_d[BIT_CEN_PMEM]             = 1'b0;
          inst_d[BIT_WEN_PMEM]             = 1'b0;
          inst_d[LSB_A_PMEM +: ADDR_W]     = p_base_q + drain_q;
          drain_d                          = drain_q + ONE;
          if (drain_q == n_act_q - ONE) state_d = S_DONE;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Weight-stationary dataflow only: these controls never assert
    inst_d[BIT_OP_MODE]  = 1'b0;
    inst_d[BIT_ACC]      = 1'b0;
    inst_d[BIT_IFIFO_WR] = 1'b0;
    inst_d[BIT_IFIFO_RD] = 1'b0;
  end

  // State, counters, latched tile parameters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      drain_q  <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      p_base_q <= '0;
      n_act_q  <= '0;
      inst_q   <= IDLE_WORD;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      drain_q  <= drain_d;
      w_base_q <= w_base_d;
      x_base_q <= x_base_d;
      p_base_q <= p_base_d;
      n_act_q  <= n_act_d;
      inst_q   <= inst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: a reference model expands each
// accepted tile into its expected per-cycle instruction stream and pushes
// it into a scoreboard queue; a monitor pops one entry per cycle and
// compares inst, busy and done.
module tb_inst_sequencer;

  localparam int ROW   = 8;
  localparam int FLUSH = 16;
  localparam logic [37:0] IDLE = 38'h01800C0000;

  typedef struct {
    logic [37:0] inst;
    logic        busy;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        relu = 1'b0;
  logic        sfu_acc = 1'b0;
  logic [10:0] w_base = '0;
  logic [10:0] x_base = '0;
  logic [10:0] p_base = '0;
  logic [10:0] n_act = '0;
  logic        ofifo_valid = 1'b0;
  logic [37:0] inst;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  bit   active = 0;
  int   hold = 0;
  int   wait_cnt = 0;
  int   left = 0;
  logic [10:0] m_p = '0;
  logic [10:0] m_k = '0;
  int   valid_mode = 0;
  int   pat_cnt = 0;

  inst_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .relu        (relu),
    .sfu_acc     (sfu_acc),
    .w_base      (w_base),
    .x_base      (x_base),
    .p_base      (p_base),
    .n_act       (n_act),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  initial forever #5 clk = ~clk;

  function automatic exp_t mk(input logic [37:0] w, input logic b, input logic d);
    exp_t e;
    e.inst = w;
    e.busy = b;
    e.done = d;
    return e;
  endfunction

  // One fetch phase: cnt reads from base, each followed a cycle later by an L0 write
  task automatic push_fetch(input logic [10:0] base, input int cnt, input logic ld);
    logic [37:0] w;
    logic [10:0] a;
    for (int c = 0; c <= cnt; c++) begin
      w = IDLE;
      w[35] = ld;
      if (c < cnt) begin
        a = base + 11'(c);
        w[19] = 1'b0;
        w[17:7] = a;
      end
      if (c > 0) w[2] = 1'b1;
      exp_q.push_back(mk(w, 1'b1, 1'b0));
    end
  endtask

  task automatic push_repeat(input logic [37:0] w, input int cnt);
    for (int c = 0; c < cnt; c++) exp_q.push_back(mk(w, 1'b1, 1'b0));
  endtask

  // Reference model: expands an accepted tile into the expected stream
  initial begin
    logic [37:0] w;
    int n;
    forever begin
      @(posedge clk);
      if (!reset) begin
        exp_q.delete();
        active = 0;
        hold = 0;
      end else if (hold > 0) begin
        hold--;
      end else if (active) begin
        if (wait_cnt > 0) begin
          wait_cnt--;
        end else if (ofifo_valid) begin
          w = IDLE;
          w[37] = relu;
          w[36] = sfu_acc;
          w[32] = 1'b0;
          w[31] = 1'b0;
          w[30:20] = m_p + m_k;
          w[6] = 1'b1;
          exp_q.push_back(mk(w, 1'b1, 1'b0));
          m_k = m_k + 11'd1;
          left--;
          if (left == 0) begin
            exp_q.push_back(mk(IDLE, 1'b0, 1'b1));
            active = 0;
            hold = 1;
          end
        end else begin
          exp_q.push_back(mk(IDLE, 1'b1, 1'b0));
        end
      end else if (start) begin
        n = int'(n_act);
        if (n == 0) begin
          exp_q.push_back(mk(IDLE, 1'b0, 1'b0));
          exp_q.push_back(mk(IDLE, 1'b0, 1'b1));
          hold = 1;
        end else begin
          exp_q.push_back(mk(IDLE, 1'b1, 1'b0));
          push_fetch(w_base, ROW, 1'b1);
          w = IDLE; w[3] = 1'b1; w[0] = 1'b1;
          push_repeat(w, ROW);
          push_repeat(IDLE, FLUSH);
          push_fetch(x_base, n, 1'b0);
          w = IDLE; w[3] = 1'b1; w[1] = 1'b1;
          push_repeat(w, n);
          wait_cnt = (ROW + 1) + ROW + FLUSH + (n + 1) + n;
          left = n;
          m_p = p_base;
          m_k = '0;
          active = 1;
        end
      end
    end
  end

  // Monitor: one scoreboard entry per cycle; quiet cycles expect the idle word
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk(IDLE, 1'b0, 1'b0);
      checks++;
      if (inst !== e.inst) begin
        errors++;
        $display("FAIL inst t=%0t got=%h exp=%h", $time, inst, e.inst);
      end
      checks++;
      if (busy !== e.busy) begin
        errors++;
        $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, e.busy);
      end
      checks++;
      if (done !== e.done) begin
        errors++;
        $display("FAIL done t=%0t got=%b exp=%b", $time, done, e.done);
      end
    end
  end

  // OFIFO valid source: constant, 1-0-0 pattern, or random
  initial forever begin
    @(negedge clk);
    case (valid_mode)
      0: ofifo_valid = 1'b1;
      1: begin
        ofifo_valid = (pat_cnt % 3 == 0);
        pat_cnt++;
      end
      default: ofifo_valid = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 5000 && (active || hold > 0 || exp_q.size() > 0); i++) @(negedge clk);
    if (active || hold > 0 || exp_q.size() > 0) begin
      errors++;
      $display("FAIL timeout_%s got=busy exp=idle", name);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_tile(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb,
                          input logic [10:0] n, input logic r, input logic s,
                          input int mode, input bit restart, input string name);
    valid_mode = mode;
    pat_cnt = 0;
    @(negedge clk);
    w_base = wb; x_base = xb; p_base = pb; n_act = n;
    relu = r; sfu_acc = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble the tile inputs: the sequencer must use the latched copies
    w_base = 11'($urandom); x_base = 11'($urandom);
    p_base = 11'($urandom); n_act = 11'($urandom_range(1, 5));
    if (restart) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    $display("tile %s w=%0d x=%0d p=%0d n=%0d issued", name, wb, xb, pb, n);
    wait_idle(name);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_tile(11'd0,    11'd100,  11'd5,    11'd4, 1'b1, 1'b0, 0, 1'b1, "basic");
    run_tile(11'd10,   11'd200,  11'd300,  11'd6, 1'b0, 1'b1, 1, 1'b0, "toggle");
    run_tile(11'd7,    11'd2040, 11'd2046, 11'd4, 1'b1, 1'b1, 0, 1'b0, "pwrap");
    run_tile(11'd50,   11'd60,   11'd70,   11'd0, 1'b0, 1'b0, 0, 1'b1, "empty");
    run_tile(11'd2044, 11'd2045, 11'd1,    11'd5, 1'b0, 1'b0, 2, 1'b0, "xwrap");

    // Reset in the middle of EXEC: outputs go idle, no done pulse afterwards
    valid_mode = 0;
    @(negedge clk);
    w_base = 11'd3; x_base = 11'd30; p_base = 11'd300; n_act = 11'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (58) @(negedge clk);
    reset = 1'b0;
    $display("tile reset_mid_exec reset asserted");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      run_tile(11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom_range(1, 12)),
               1'($urandom), 1'($urandom), 2, 1'($urandom), "random");
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
